// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generates VGA raster timing. The block runs a free horizontal pixel
//   counter and a vertical line counter. From those it derives the sync
//   pulses, the visible-area flag and a once-per-frame start pulse.
//   Every timed output is a single flop. Each flop is loaded from the
//   *next* counter value, so it always matches the DrawX/DrawY pair
//   presented in the same cycle.
//
// Parameters:
//   H_VISIBLE/H_FP/H_SYNC/H_BP : horizontal active, front porch, sync, back porch
//   V_VISIBLE/V_FP/V_SYNC/V_BP : vertical   active, front porch, sync, back porch
//
// Ports:
//   pixel_clk    in   pixel clock, all state updates on its rising edge
//   Reset        in   asynchronous, active-high reset
//   DrawX        out  [9:0] horizontal pixel counter, 0..H_TOTAL-1
//   DrawY        out  [9:0] vertical line counter, 0..V_TOTAL-1
//   hs           out  horizontal sync, active-low
//   vs           out  vertical sync, active-low
//   blank        out  1 = visible region, 0 = blanking interval
//   hs_d         out  hs delayed one cycle (for a registered RGB stage)
//   vs_d         out  vs delayed one cycle
//   frame_start  out  one-cycle pulse while DrawX=0 and DrawY=0
//   frame_cnt    out  [15:0] completed-frame counter, wraps
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        pixel_clk,
  input  logic        Reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        hs_d,
  output logic        vs_d,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // The counters are 10 bits wide, so a raster larger than 1024 in
  // either direction cannot be represented. Refuse to elaborate.
  generate
    if (H_TOTAL > 1024 || H_TOTAL < 1) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL (%0d) must be in 1..1024", H_TOTAL);
    end
    if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL (%0d) must be in 1..1024", V_TOTAL);
    end
  endgenerate

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  // The region bounds can reach 1024, so comparisons are done in 11 bits.
  localparam logic [10:0] HS_START_W = 11'(HS_START);
  localparam logic [10:0] HS_END_W   = 11'(HS_END);
  localparam logic [10:0] VS_START_W = 11'(VS_START);
  localparam logic [10:0] VS_END_W   = 11'(VS_END);
  localparam logic [10:0] H_VIS_W    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_W    = 11'(V_VISIBLE);

  // The hs_d/vs_d port names are already taken by the delayed syncs.
  // Internally, the sync flops are therefore called hsync/vsync, and the
  // one-cycle delay flops are called hs_dly/vs_dly.
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        hs_dly_q, hs_dly_d;
  logic        vs_dly_q, vs_dly_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        line_end;
  logic [10:0] x_next_w;
  logic [10:0] y_next_w;

  // Raster counters. X always advances. Y advances only on the edge
  // where X wraps, and wraps itself after the last line.
  always_comb begin
    line_end = (x_q == H_LAST);
    x_d      = line_end ? 10'd0 : x_q + 10'd1;
    y_d      = y_q;
    if (line_end) begin
      y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    end
  end

  // Decode from the next counter values. After the edge, the registered
  // flags then line up with the DrawX/DrawY they describe.
  always_comb begin
    x_next_w      = {1'b0, x_d};
    y_next_w      = {1'b0, y_d};
    hsync_d       = !((x_next_w >= HS_START_W) && (x_next_w < HS_END_W));
    vsync_d       = !((y_next_w >= VS_START_W) && (y_next_w < VS_END_W));
    blank_d       = (x_next_w < H_VIS_W) && (y_next_w < V_VIS_W);
    hs_dly_d      = hsync_q;
    vs_dly_d      = vsync_q;
    frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
    frame_cnt_d   = frame_cnt_q + {15'd0, frame_start_d};
  end

  // State register. The reset values describe the pixel at (0,0): no
  // sync is active and the pixel is visible. frame_start stays low
  // because the first edge after release moves to DrawX=1.
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b1;
      hs_dly_q      <= 1'b1;
      vs_dly_q      <= 1'b1;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      hs_dly_q      <= hs_dly_d;
      vs_dly_q      <= vs_dly_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign blank       = blank_q;
  assign hs_d        = hs_dly_q;
  assign vs_d        = vs_dly_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
REQ-002 Ports, one per line: name, direction, width, meaning. Reset is Reset, asynchronous, active-high; the clock is pixel_clk.
- pixel_clk  in  1  pixel clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-high reset
- DrawX  out  10  horizontal pixel counter, 0..H_TOTAL-1
- DrawY  out  10  vertical line counter, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active-low, aligned with DrawX/DrawY
- vs  out  1  vertical sync, active-low, aligned with DrawX/DrawY
- blank  out  1  1 = visible region, 0 = blanking interval
- hs_d  out  1  hs delayed 1 cycle, aligned to a registered RGB stage
- vs_d  out  1  vs delayed 1 cycle
- frame_start  out  1  1-cycle pulse when DrawX=0 and DrawY=0
- frame_cnt  out  16  completed-frame counter, wraps

Function
REQ-003 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525); both are elaboration-time constants.
REQ-004 DrawX shall increment by 1 every pixel_clk; when DrawX = H_TOTAL-1 it shall wrap to 0 on the next edge.
REQ-005 DrawY shall increment only on the edge where DrawX wraps; when DrawY = V_TOTAL-1 and DrawX wraps, DrawY shall wrap to 0.
REQ-006 DrawX and DrawY shall keep counting through blanking. No hold or freeze exists.
REQ-007 hs shall be 0 exactly when H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751), and 1 otherwise.
REQ-008 vs shall be 0 exactly when V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491), and 1 otherwise. The vs rising edge, at the transition DrawY 491->492, is the per-frame tick that downstream game logic consumes.
REQ-009 blank shall be 1 exactly when DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-010 hs, vs and blank shall be registered and consistent with the DrawX/DrawY values presented in the same cycle (zero relative latency). They shall be computed from next-state counter values.
REQ-011 hs_d and vs_d shall equal hs and vs from the previous cycle.
REQ-012 frame_start shall be 1 for exactly one cycle per frame: the cycle in which DrawX=0 and DrawY=0 are presented. It shall not assert on the first cycle after reset release.
REQ-013 frame_cnt shall increment by 1 when frame_start asserts; it wraps 0xFFFF -> 0x0000.
REQ-014 Counter arithmetic is unsigned 10-bit. Parameters shall satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024; a violation is an elaboration error.
REQ-015 There shall be no glitches on hs, vs or blank: each is a single flop output.

Reset
REQ-016 While Reset=1, outputs shall hold: DrawX=0, DrawY=0, hs=1, vs=1, hs_d=1, vs_d=1, blank=1, frame_start=0, frame_cnt=0.
REQ-017 Reset asserted mid-frame shall force the REQ-016 values immediately, without waiting for a clock edge.
REQ-018 On release, the first pixel_clk edge shall produce DrawX=1, DrawY=0.

Verification
REQ-019 Release reset, run 800 clocks -> DrawX sequence 1..799 then 0; DrawY goes 0->1 on the wrap edge; blank=0 first at DrawX=640.
REQ-020 Run one full frame (420000 clocks) -> hs low for 96 cycles per line, starting at DrawX=656; vs low for 1600 cycles, covering DrawY=490..491.
REQ-021 Check at DrawX=799, DrawY=524 -> next edge gives DrawX=0, DrawY=0, frame_start=1, frame_cnt=1.
REQ-022 Compare hs_d and vs_d against hs and vs over a full line -> identical waveform shifted by exactly 1 cycle.
REQ-023 Assert Reset at DrawX=300, DrawY=200 between clock edges -> all outputs take REQ-016 values before the next edge. Release reset -> count resumes from 1,0.
REQ-024 Preload frame_cnt to 0xFFFF via 65535 frames, or a force in simulation, then let the next frame start -> frame_cnt=0x0000 and frame_start still pulses once.
